// File: rtl/pool_pkg.sv
// -----------------------------------------------------------------------------
// pool_pkg
// Shared types and sizing helpers for the streaming pooling stage.
//   pool_mode_e : pooling operator selector (max / floor average)
//   acc_width() : accumulator width needed to sum a full PoolSize x PoolSize
//                 window of BitSize samples without overflow
//   pool_shift(): arithmetic right shift that turns a window sum into its
//                 floor average
// -----------------------------------------------------------------------------
package pool_pkg;

    typedef enum logic {
        POOL_MAX = 1'b0,
        POOL_AVG = 1'b1
    } pool_mode_e;

    function automatic int pool_shift(input int pool_size);
        return 2 * $clog2(pool_size);
    endfunction

    function automatic int acc_width(input int bit_size, input int pool_size);
        return bit_size + pool_shift(pool_size);
    endfunction

endpackage

// File: rtl/pool_lane_combine.sv
// -----------------------------------------------------------------------------
// pool_lane_combine
// Combines one incoming lane sample with that lane's running window value.
// Ports:
//   i_start  : first pixel of a window; the sample replaces the accumulator
//   i_acc    : current accumulator entry (signed, AccW bits)
//   i_sample : incoming signed lane sample (BitSize bits)
//   i_mode   : POOL_MAX keeps the signed maximum, POOL_AVG keeps the sum
//   o_acc    : next accumulator value
// -----------------------------------------------------------------------------
module pool_lane_combine
    import pool_pkg::*;
#(
    parameter int BitSize = 4,
    parameter int AccW    = 6
) (
    input  logic                      i_start,
    input  logic signed [AccW-1:0]    i_acc,
    input  logic signed [BitSize-1:0] i_sample,
    input  pool_mode_e                i_mode,
    output logic signed [AccW-1:0]    o_acc
);

    logic signed [AccW-1:0] w_ext;

    assign w_ext = {{(AccW-BitSize){i_sample[BitSize-1]}}, i_sample};

    always_comb begin
        o_acc = w_ext;
        if (!i_start) begin
            if (i_mode == POOL_MAX) begin
                o_acc = (w_ext > i_acc) ? w_ext : i_acc;
            end else begin
                o_acc = i_acc + w_ext;
            end
        end
    end

endmodule

// File: rtl/pool_stream_layer.sv
// -----------------------------------------------------------------------------
// pool_stream_layer
// Streaming multi-channel non-overlapping pooling (max or floor average).
// Pixels arrive in raster order, all Channels lanes per beat; one pooled pixel
// leaves per PoolSize x PoolSize window, one cycle after its last pixel.
// Ports:
//   clk, res_n            : clock, asynchronous active-low reset
//   in_valid/in_ready     : upstream handshake (in_ready = !out_valid || out_ready)
//   in_data               : lane c at [c*BitSize +: BitSize], signed
//   out_valid/out_ready   : downstream handshake, output held until accepted
//   out_data              : pooled lanes, same packing as in_data
//   out_last              : marks the final pooled pixel of an image
// -----------------------------------------------------------------------------
module pool_stream_layer
    import pool_pkg::*;
#(
    parameter int BitSize    = 4,
    parameter int Channels   = 2,
    parameter int ImageWidth = 4,
    parameter int PoolSize   = 2,
    parameter int Mode       = 0
) (
    input  logic                        clk,
    input  logic                        res_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [Channels*BitSize-1:0] in_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [Channels*BitSize-1:0] out_data,
    output logic                        out_last
);

    localparam int AccW  = acc_width(BitSize, PoolSize);
    localparam int Shift = pool_shift(PoolSize);
    localparam int Log2P = $clog2(PoolSize);
    localparam int NumOw = ImageWidth / PoolSize;
    localparam int CntW  = (ImageWidth > 1) ? $clog2(ImageWidth) : 1;
    localparam int OwW   = (NumOw > 1) ? $clog2(NumOw) : 1;
    localparam pool_mode_e ModeE = (Mode == 1) ? POOL_AVG : POOL_MAX;

    if ((ImageWidth % PoolSize) != 0) begin : g_err_width
        $error("pool_stream_layer: ImageWidth must be a multiple of PoolSize");
    end
    if ((PoolSize < 2) || ((PoolSize & (PoolSize - 1)) != 0)) begin : g_err_pool
        $error("pool_stream_layer: PoolSize must be a power of two >= 2");
    end

    // Max mode keeps a sign-extended sample, so its low bits are the answer;
    // average mode floors the window sum by an arithmetic shift.
    function automatic logic [BitSize-1:0] pool_result(input logic signed [AccW-1:0] acc);
        logic signed [AccW-1:0] shifted;
        shifted = (ModeE == POOL_AVG) ? (acc >>> Shift) : acc;
        return shifted[BitSize-1:0];
    endfunction

    logic [CntW-1:0]                r_col;
    logic [CntW-1:0]                r_row;
    logic signed [AccW-1:0]         r_acc [NumOw][Channels];
    logic                           r_out_valid_p1;
    logic [Channels*BitSize-1:0]    r_out_data_p1;
    logic                           r_out_last_p1;

    logic                           w_accept;
    logic [Log2P-1:0]               w_wc;
    logic [Log2P-1:0]               w_wr;
    logic [OwW-1:0]                 w_ow;
    logic                           w_start;
    logic                           w_done;
    logic                           w_col_end;
    logic                           w_row_end;
    logic signed [AccW-1:0]         w_next [Channels];
    logic [Channels*BitSize-1:0]    w_result;

    assign in_ready  = !r_out_valid_p1 || out_ready;
    assign w_accept  = in_valid && in_ready;
    assign w_wc      = r_col[Log2P-1:0];
    assign w_wr      = r_row[Log2P-1:0];
    assign w_ow      = OwW'(r_col >> Log2P);
    assign w_start   = (w_wc == '0) && (w_wr == '0);
    assign w_done    = (&w_wc) && (&w_wr);
    assign w_col_end = (r_col == CntW'(ImageWidth - 1));
    assign w_row_end = (r_row == CntW'(ImageWidth - 1));

    // Stage p0: combine each lane with its column's accumulator entry
    for (genvar c = 0; c < Channels; c++) begin : g_lane
        pool_lane_combine #(
            .BitSize (BitSize),
            .AccW    (AccW)
        ) u_combine (
            .i_start  (w_start),
            .i_acc    (r_acc[w_ow][c]),
            .i_sample (in_data[c*BitSize +: BitSize]),
            .i_mode   (ModeE),
            .o_acc    (w_next[c])
        );
        assign w_result[c*BitSize +: BitSize] = pool_result(w_next[c]);
    end

    // Stage p1: counters, accumulator row buffer and the output register
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            r_col          <= '0;
            r_row          <= '0;
            r_out_valid_p1 <= 1'b0;
            r_out_data_p1  <= '0;
            r_out_last_p1  <= 1'b0;
            for (int i = 0; i < NumOw; i++) begin
                for (int c = 0; c < Channels; c++) begin
                    r_acc[i][c] <= '0;
                end
            end
        end else begin
            if (w_accept) begin
                for (int c = 0; c < Channels; c++) begin
                    r_acc[w_ow][c] <= w_next[c];
                end
                if (w_col_end) begin
                    r_col <= '0;
                    r_row <= w_row_end ? '0 : r_row + CntW'(1);
                end else begin
                    r_col <= r_col + CntW'(1);
                end
            end

            // A completion reloads the register even while the old value is
            // being popped, so back-to-back windows never bubble.
            if (w_accept && w_done) begin
                r_out_valid_p1 <= 1'b1;
                r_out_data_p1  <= w_result;
                r_out_last_p1  <= w_col_end && w_row_end;
            end else if (out_ready) begin
                r_out_valid_p1 <= 1'b0;
                r_out_last_p1  <= 1'b0;
            end
        end
    end

    assign out_valid = r_out_valid_p1;
    assign out_data  = r_out_data_p1;
    assign out_last  = r_out_last_p1;

endmodule
